write_coprocessador: RTL and testbench

Nios II custom-instruction block that writes CPU data into the coprocessor's 128-word dual-port memory. It is the write-side counterpart of the read custom instruction and drives the memory's write port. It supports a single-word write or a burst fill of up to 128 consecutive addresses from one instruction, and stalls while the coprocessor holds the memory busy.

---
 rtl/write_coprocessador.sv | 142 ++++++++++++++
 tb/tb_write_coprocessador.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_coprocessador.sv
// Nios II custom instruction that writes CPU data into the coprocessor memory.
// Supports single-word writes and burst fills, and stalls while the coprocessor owns the memory.
module write_coprocessador #(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned MAX_BURST  = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic [31:0]           dataa,
   input  logic [31:0]           datab,
   input  logic                  cop_busy,
   output logic [31:0]           result,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] wraddress,
   output logic [31:0]           wrdata,
   output logic                  wren,
   output logic                  busy
);

   localparam int unsigned LenW = $clog2(MAX_BURST) + 1;

   typedef enum logic [1:0] {StIdle, StWrite, StFinish} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic                  inc_q, inc_d;
   logic [LenW-1:0]       len_q, len_d;
   logic [LenW-1:0]       rem_q, rem_d;
   logic [31:0]           result_q, result_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] wraddress_q, wraddress_d;
   logic [31:0]           wrdata_q, wrdata_d;
   logic                  wren_q, wren_d;

   logic [7:0]            burst_l;
   logic [LenW-1:0]       len_sat;
   logic                  unused_datab;

   assign burst_l      = datab[15:8];
   assign unused_datab = ^{datab[31:17], datab[7]};

   // L of 0 or 1 both mean a single word; anything above the depth saturates.
   always_comb begin
      len_sat = LenW'(burst_l);
      if (burst_l <= 8'd1) begin
         len_sat = LenW'(1);
      end else if (32'(burst_l) > MAX_BURST) begin
         len_sat = LenW'(MAX_BURST);
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      inc_d       = inc_q;
      len_d       = len_q;
      rem_d       = rem_q;
      result_d    = result_q;
      wraddress_d = wraddress_q;
      wrdata_d    = wrdata_q;
      done_d      = 1'b0;
      wren_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (clk_en && start) begin
               addr_d  = datab[ADDR_WIDTH-1:0];
               data_d  = dataa;
               inc_d   = datab[16];
               len_d   = len_sat;
               rem_d   = len_sat;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (clk_en && !cop_busy) begin
               wren_d      = 1'b1;
               wraddress_d = addr_q;
               wrdata_d    = data_q;
               addr_d      = addr_q + ADDR_WIDTH'(1);
               if (inc_q) begin
                  data_d = data_q + 32'd1;
               end
               rem_d = rem_q - LenW'(1);
               if (rem_q == LenW'(1)) begin
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            if (clk_en) begin
               done_d   = 1'b1;
               result_d = 32'(len_q);
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         data_q      <= '0;
         inc_q       <= 1'b0;
         len_q       <= '0;
         rem_q       <= '0;
         result_q    <= '0;
         done_q      <= 1'b0;
         wraddress_q <= '0;
         wrdata_q    <= '0;
         wren_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         inc_q       <= inc_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         result_q    <= result_d;
         done_q      <= done_d;
         wraddress_q <= wraddress_d;
         wrdata_q    <= wrdata_d;
         wren_q      <= wren_d;
      end
   end

   assign result    = result_q;
   assign done      = done_q;
   assign wraddress = wraddress_q;
   assign wrdata    = wrdata_q;
   assign wren      = wren_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_write_coprocessador.sv
// Directed bench for write_coprocessador: a queue of expected writes and an expected
// done cycle, both derived from the instruction fields, checked every cycle.
module tb_write_coprocessador;

   logic        clk = 1'b0;
   logic        reset, clk_en, start, cop_busy;
   logic [31:0] dataa, datab;
   logic [31:0] result, wrdata;
   logic        done, wren, busy;
   logic [6:0]  wraddress;

   always #5 clk = ~clk;

   write_coprocessador #(
      .ADDR_WIDTH(7),
      .MAX_BURST (128)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .clk_en   (clk_en),
      .start    (start),
      .dataa    (dataa),
      .datab    (datab),
      .cop_busy (cop_busy),
      .result   (result),
      .done     (done),
      .wraddress(wraddress),
      .wrdata   (wrdata),
      .wren     (wren),
      .busy     (busy)
   );

   typedef struct {
      logic [6:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         w;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          e0 = 0;
   int          exp_done_cyc = -1;
   logic [31:0] exp_result = 32'd0;
   logic        en_ok = 1'b0;
   logic [31:0] dut_mem[128];
   int          wr_cnt[128];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      en_ok <= clk_en && !cop_busy && !reset;
   end

   // Every cycle: each write must be the next expected word; done only when predicted.
   always @(negedge clk) begin
      if (wren) begin
         chk("issue_enable", 32'(en_ok), 32'd1);
         chk("busy_during_write", 32'(busy), 32'd1);
         if (exp_q.size() == 0) begin
            chk("write_expected", 32'(exp_q.size()), 32'd1);
         end else begin
            w = exp_q.pop_front();
            chk("wraddress", 32'(wraddress), 32'(w.a));
            chk("wrdata", wrdata, w.d);
         end
         dut_mem[wraddress] = wrdata;
         wr_cnt[wraddress]++;
      end
      if (done || cyc == exp_done_cyc) begin
         chk("done_cycle", cyc, exp_done_cyc);
         chk("done", 32'(done), 32'd1);
         chk("result", result, exp_result);
         chk("wren_at_done", 32'(wren), 32'd0);
      end
   end

   task automatic clear_counts();
      for (int i = 0; i < 128; i++) wr_cnt[i] = 0;
   endtask

   // Caller sits just after a falling edge; returns one cycle later with e0 = start edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input int stalls,
                        input int n_written);
      int l, len, n;
      l   = int'(b[15:8]);
      len = (l <= 1) ? 1 : ((l > 128) ? 128 : l);
      n   = (n_written >= 0) ? n_written : len;
      start = 1'b1;
      dataa = a;
      datab = b;
      for (int i = 0; i < n; i++) begin
         wr_t x;
         x.a = 7'((int'(b[6:0]) + i) % 128);
         x.d = b[16] ? a + 32'(i) : a;
         exp_q.push_back(x);
      end
      @(negedge clk);
      start = 1'b0;
      e0    = cyc;
      if (n_written < 0) begin
         exp_result   = 32'(len);
         exp_done_cyc = e0 + len + 1 + stalls;
      end else begin
         exp_done_cyc = -1;
      end
   endtask

   task automatic wait_done();
      int guard = 0;
      while (cyc < exp_done_cyc && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("done_within_budget", 32'(guard < 1000), 32'd1);
      chk("all_words_written", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1; clk_en = 1'b1; start = 1'b0; cop_busy = 1'b0;
      dataa = '0; datab = '0;
      clear_counts();
      repeat (3) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wren", 32'(wren), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wraddress", 32'(wraddress), 32'd0);
      chk("rst_wrdata", wrdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single write, L=0
      issue(32'hDEAD_BEEF, 32'h0000_0005, 0, -1);
      @(negedge clk);
      chk("single_wren", 32'(wren), 32'd1);
      chk("single_addr", 32'(wraddress), 32'd5);
      chk("single_data", wrdata, 32'hDEAD_BEEF);
      wait_done();
      chk("single_result", result, 32'd1);
      repeat (2) @(negedge clk);
      chk("result_holds", result, 32'd1);

      // Reset held 3 cycles while idle
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_rst_result", result, 32'd0);
      chk("idle_rst_wraddress", 32'(wraddress), 32'd0);
      chk("idle_rst_wrdata", wrdata, 32'd0);
      chk("idle_rst_done", 32'(done), 32'd0);
      chk("idle_rst_wren", 32'(wren), 32'd0);
      chk("idle_rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Burst with address wrap and data increment
      clear_counts();
      issue(32'h0000_0010, 32'h0001_047E, 0, -1);
      wait_done();
      chk("burst_done_latency", 32'(cyc - (e0 - 1)), 32'd6);
      chk("burst_mem126", dut_mem[126], 32'h10);
      chk("burst_mem127", dut_mem[127], 32'h11);
      chk("burst_mem0", dut_mem[0], 32'h12);
      chk("burst_mem1", dut_mem[1], 32'h13);
      chk("burst_result", result, 32'd4);
      @(negedge clk);

      // Saturated burst covers every address once
      clear_counts();
      issue(32'hA5A5_A5A5, 32'h0000_FF00, 0, -1);
      wait_done();
      n = 0;
      for (int i = 0; i < 128; i++) begin
         if (wr_cnt[i] == 1 && dut_mem[i] == 32'hA5A5_A5A5) n++;
      end
      chk("sat_coverage", 32'(n), 32'd128);
      chk("sat_result", result, 32'h80);
      @(negedge clk);

      // Stalls: cop_busy for 3 cycles after word 2, clk_en low 1 cycle after word 5
      clear_counts();
      issue(32'h0000_0100, 32'h0001_0810, 4, -1);
      repeat (3) @(negedge clk);
      cop_busy = 1'b1;
      repeat (3) @(negedge clk);
      cop_busy = 1'b0;
      repeat (3) @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
      clk_en = 1'b1;
      wait_done();
      chk("stall_done_latency", 32'(cyc - (e0 - 1)), 32'd14);
      chk("stall_mem17", dut_mem[8'h17], 32'h107);
      @(negedge clk);

      // Starts during WRITE and FINISH are ignored; start right after done runs
      issue(32'h1111_1111, 32'h0000_0320, 0, -1);
      @(negedge clk);
      start = 1'b1; dataa = 32'h0000_0BAD; datab = 32'h0000_0510;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("finish_busy", 32'(busy), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("ign_result", result, 32'd3);
      issue(32'h2222_2222, 32'h0001_0240, 0, -1);
      wait_done();
      chk("next_mem41", dut_mem[8'h41], 32'h2222_2223);
      @(negedge clk);

      // Reset after 4 words of a 10-word burst
      clear_counts();
      issue(32'h0000_0300, 32'h0001_0A50, 0, 4);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_wren", 32'(wren), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
      n = 0;
      for (int i = 0; i < 128; i++) n += wr_cnt[i];
      chk("abort_total_writes", 32'(n), 32'd4);
      chk("abort_mem53", dut_mem[8'h53], 32'h303);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
